// File: rtl/horner_poly_eval_if.sv
// Operand/result bundle between the switch/LED board top and the evaluator.
interface horner_poly_eval_if #(parameter int WIDTH = 8);
    logic             go;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_result;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [3:0]       load_idx;

    modport master (output go, data_in,
                    input  data_result, overflow, busy, done, load_idx);
    modport slave  (input  go, data_in,
                    output data_result, overflow, busy, done, load_idx);
endinterface

// File: rtl/horner_poly_eval.sv
// Horner polynomial evaluator: loads c[D]..c[0] then x via the go press/release
// handshake, then alternates one multiply and one add per cycle until y is formed.
module horner_poly_eval #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic              clk,
    input  logic              resetn,
    horner_poly_eval_if.slave bus
);
    typedef enum logic [2:0] {
        S_LOAD_COEF, S_LOAD_COEF_WAIT, S_LOAD_X, S_LOAD_X_WAIT, S_MUL, S_ADD, S_DONE
    } state_t;

    localparam logic [3:0] DEG = 4'(DEGREE);

    state_t                    state, state_nxt;
    logic [DEGREE:0][WIDTH-1:0] coef;
    logic [WIDTH-1:0]          x, acc, coef_k, result;
    logic [3:0]                idx, k;
    logic                      ovf_acc, ovf_r, done_r;
    logic [2*WIDTH-1:0]        prod;
    logic [WIDTH:0]            sum;

    // Single shared multiplier and adder; upper product bits / carry feed overflow.
    assign prod = (2*WIDTH)'(acc) * (2*WIDTH)'(x);
    assign sum  = {1'b0, acc} + {1'b0, coef_k};

    // Coefficient select for the current Horner step.
    always_comb begin
        coef_k = '0;
        for (int i = 0; i <= DEGREE; i++)
            if (k == 4'(i)) coef_k = coef[i];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_LOAD_COEF;
        else         state <= state_nxt;
    end

    // Next-state logic: each operand needs a press then a full release of go.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD_COEF:      if (bus.go)  state_nxt = S_LOAD_COEF_WAIT;
            S_LOAD_COEF_WAIT: if (!bus.go) state_nxt = (idx == 4'd0) ? S_LOAD_X : S_LOAD_COEF;
            S_LOAD_X:         if (bus.go)  state_nxt = S_LOAD_X_WAIT;
            S_LOAD_X_WAIT:    if (!bus.go) state_nxt = S_MUL;
            S_MUL:            state_nxt = S_ADD;
            S_ADD:            state_nxt = (k == 4'd0) ? S_DONE : S_MUL;
            S_DONE:           state_nxt = S_LOAD_COEF;
            default:          state_nxt = S_LOAD_COEF;
        endcase
    end

    // Operand capture and Horner datapath. The result register is written on the
    // final add so data_result and done become visible together in S_DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            coef    <= '0;
            x       <= '0;
            acc     <= '0;
            idx     <= DEG;
            k       <= '0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_LOAD_COEF: begin
                    for (int i = 0; i <= DEGREE; i++)
                        if (idx == 4'(i)) coef[i] <= bus.data_in;
                end
                S_LOAD_COEF_WAIT: if (!bus.go && idx != 4'd0) idx <= idx - 4'd1;
                S_LOAD_X: x <= bus.data_in;
                S_LOAD_X_WAIT: begin
                    if (!bus.go) begin
                        acc     <= coef[DEGREE];
                        ovf_acc <= 1'b0;
                        k       <= DEG - 4'd1;
                    end
                end
                S_MUL: begin
                    acc     <= prod[WIDTH-1:0];
                    ovf_acc <= ovf_acc | (|prod[2*WIDTH-1:WIDTH]);
                end
                S_ADD: begin
                    acc     <= sum[WIDTH-1:0];
                    ovf_acc <= ovf_acc | sum[WIDTH];
                    if (k == 4'd0) begin
                        result <= sum[WIDTH-1:0];
                        ovf_r  <= ovf_acc | sum[WIDTH];
                        done_r <= 1'b1;
                    end else begin
                        k <= k - 4'd1;
                    end
                end
                S_DONE:  idx <= DEG;
                default: idx <= DEG;
            endcase
        end
    end

    assign bus.data_result = result;
    assign bus.overflow    = ovf_r;
    assign bus.done        = done_r;
    assign bus.busy        = (state == S_MUL) || (state == S_ADD) || (state == S_DONE);
    assign bus.load_idx    = (state == S_LOAD_COEF || state == S_LOAD_COEF_WAIT) ? idx : 4'hF;
endmodule
